// File: rtl/level_debouncer_pkg.sv
// rtl/level_debouncer_pkg.sv - shared types and limits for the level debouncer
//
// Purpose: FSM state encoding and synchronizer depth limits shared by the
//          debouncer top and anything else that wants to reason about it.
// Ports:   none (package).

package level_debouncer_pkg;

  // IDLE: synchronized input agrees with the debounced level.
  // QUALIFY: a candidate level change is being timed.
  typedef enum logic {
    IDLE    = 1'b0,
    QUALIFY = 1'b1
  } state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - multi-flop single-bit clock domain crossing synchronizer
//
// Purpose: brings an asynchronous single-bit level into the clock domain
//          through a DEPTH-deep flop chain.
// Ports:
//   clock    - destination clock, rising edge
//   reset    - asynchronous, active-high; loads RESET_VALUE into every stage
//   i_async  - asynchronous input level
//   o_sync   - synchronized level (last stage of the chain)

module bit_synchronizer #(
  parameter int   DEPTH       = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  // Keep the chain flops together and away from retiming so the first stage
  // has a full period to resolve metastability.
  (* ASYNC_REG = "TRUE" *) logic [DEPTH-1:0] r_chain;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_chain <= {DEPTH{RESET_VALUE}};
    end else begin
      r_chain <= {r_chain[DEPTH-2:0], i_async};
    end
  end

  assign o_sync = r_chain[DEPTH-1];

endmodule

// File: rtl/level_debouncer.sv
// rtl/level_debouncer.sv - synchronizing level debouncer with glitch reporting
//
// Purpose: synchronizes a bouncing asynchronous level and only accepts a new
//          level once it has been seen for STABLE_CYCLES consecutive edges.
// Ports:
//   clock          - single clock, rising edge
//   reset          - asynchronous, active-high
//   level_async_in - raw, possibly bouncing, asynchronous level
//   level_out      - debounced level, synchronous to clock
//   pending_out    - high while a candidate change is being qualified
//   glitch_out     - one-cycle pulse when a candidate change is rejected

module level_debouncer
  import level_debouncer_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic level_async_in,
  output logic level_out,
  output logic pending_out,
  output logic glitch_out
);

  // Out-of-range depths are clamped into the supported window.
  localparam int DEPTH = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                         (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX :
                         SYNC_STAGES;

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  // Counter value at which the current edge is the STABLE_CYCLES-th
  // consecutive mismatch; the counter therefore never exceeds STABLE_CYCLES-1.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic             w_sync_level;
  logic             w_mismatch;
  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_level;
  logic             r_glitch;

  bit_synchronizer #(
    .DEPTH       (DEPTH),
    .RESET_VALUE (RESET_LEVEL)
  ) u_sync (
    .clock   (clock),
    .reset   (reset),
    .i_async (level_async_in),
    .o_sync  (w_sync_level)
  );

  assign w_mismatch = (w_sync_level != r_level);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_level  <= RESET_LEVEL;
      r_glitch <= 1'b0;
    end else begin
      r_glitch <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_mismatch) begin
            // A single-cycle qualification accepts immediately.
            if (STABLE_CYCLES == 1) begin
              r_level <= w_sync_level;
            end else begin
              r_state <= QUALIFY;
              r_count <= CNT_W'(1);
            end
          end
        end
        QUALIFY: begin
          if (!w_mismatch) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_glitch <= 1'b1;
          end else if (r_count == LAST_CNT) begin
            r_level <= w_sync_level;
            r_state <= IDLE;
            r_count <= '0;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
      endcase
    end
  end

  assign level_out   = r_level;
  assign pending_out = (r_state == QUALIFY);
  assign glitch_out  = r_glitch;

endmodule

// File: doc/level_debouncer.md
LEVEL_DEBOUNCER -- requirements
Module: level_debouncer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops (legal range 2..4).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 16, the consecutive-cycle count a new level must hold before acceptance (legal range 1..65535).
REQ-003 The block SHALL have parameter RESET_LEVEL, default 1'b0, the value of the synchronizer flops and level_out under reset.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all flops are on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port level_async_in, input, 1 bit: raw, possibly bouncing, asynchronous level.
REQ-007 The block SHALL have port level_out, output, 1 bit: debounced level, synchronous to clock; the intended feed for a downstream edge-to-pulse stage.
REQ-008 The block SHALL have port pending_out, output, 1 bit: high while a candidate level change is being qualified.
REQ-009 The block SHALL have port glitch_out, output, 1 bit: one-cycle pulse when a candidate change is rejected.

Function
REQ-010 level_async_in SHALL pass through a SYNC_STAGES-deep flop chain; the last stage output is sync_level.
REQ-011 The FSM SHALL have two states: IDLE (sync_level == level_out) and QUALIFY (sync_level != level_out).
REQ-012 In IDLE, when sync_level != level_out, the FSM SHALL go to QUALIFY on the next edge, with counter = 1.
REQ-013 In QUALIFY, the counter SHALL increment on each edge where sync_level != level_out.
REQ-014 When the mismatch has been seen on STABLE_CYCLES consecutive edges, level_out SHALL take sync_level on that edge, the FSM SHALL enter IDLE, and the counter SHALL clear.
REQ-015 For STABLE_CYCLES == 1, level_out SHALL update on the first mismatching edge, with no QUALIFY cycle.
REQ-016 In QUALIFY, if sync_level == level_out on an edge, the FSM SHALL return to IDLE, clear the counter, and assert glitch_out for exactly the following cycle.
REQ-017 Total latency from a clean, bounce-free input transition to the level_out change SHALL be SYNC_STAGES + STABLE_CYCLES clock edges, with up to one extra edge of synchronizer uncertainty.
REQ-018 The counter width SHALL be clog2(STABLE_CYCLES+1) bits, and the counter SHALL never wrap.
REQ-019 pending_out SHALL be high exactly when the FSM is in QUALIFY.
REQ-020 level_out SHALL be a flop output and SHALL change at most once per STABLE_CYCLES cycles.
REQ-021 glitch_out and a level_out update SHALL never be asserted in the same cycle.

Reset
REQ-022 While reset is high, the synchronizer flops and level_out SHALL equal RESET_LEVEL, the FSM SHALL be in IDLE, the counter SHALL be 0, and pending_out and glitch_out SHALL be 0, independent of clock.
REQ-023 Reset asserted during QUALIFY SHALL abandon the candidate without asserting glitch_out.
REQ-024 After reset deasserts, qualification SHALL restart from an empty synchronizer.

Structure
REQ-025 A shared package SHALL hold the FSM state enum (IDLE, QUALIFY) and the SYNC_STAGES legal limits.
REQ-026 The synchronizer chain SHALL be a separate sub-module, bit_synchronizer (parameters DEPTH and RESET_VALUE), reusable elsewhere.
REQ-027 The sub-module SHALL carry the team's CDC/ASYNC_REG attributes, and no other logic SHALL sample level_async_in.

Verification (SYNC_STAGES=2, STABLE_CYCLES=4, RESET_LEVEL=0 unless noted)
REQ-028 Clean rise of level_async_in held high -> level_out rises 6 edges later, pending_out high for 3 cycles, and glitch_out stays 0.
REQ-029 A 3-cycle high pulse on level_async_in -> level_out stays 0 and glitch_out pulses exactly once.
REQ-030 Bounce pattern 1,0,1,1,0,1,1,1,1 -> level_out rises only after the final 4-cycle-stable run, and glitch_out pulses twice.
REQ-031 Reset asserted during the 2nd QUALIFY cycle -> level_out is 0, pending_out is 0, and glitch_out is 0 immediately; after release with the input still high, level_out rises 6 edges later.
REQ-032 With STABLE_CYCLES=1, a clean fall from 1 to 0 -> level_out falls 3 edges later, and pending_out is never asserted.
REQ-033 With RESET_LEVEL=1 and the input held 1 through reset -> level_out stays 1, and there is no pending_out or glitch_out activity.
